// File: rtl/router_1xn.sv
// router_1xn: one byte-serial input steered to NUM_PORTS output FIFOs by the
// header's destination field. It checks packet parity, drops packets with an
// out-of-range destination, and flushes any port left unread for TIMEOUT cycles.

// One output port: a count-based FIFO with a registered read port and an
// unread-timeout flush.
module router_port_fifo #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 30
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_rd,
  output logic              o_vld,
  output logic              o_full,
  output logic [DATA_W-1:0] o_dout
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  logic [DEPTH-1:0][DATA_W-1:0] r_mem;
  logic [PTR_W-1:0]             r_wptr, r_rptr;
  logic [CNT_W-1:0]             r_cnt;
  logic [TMR_W-1:0]             r_tmr;
  logic [DATA_W-1:0]            r_dout;
  logic                         w_rd, w_wr, w_idle, w_flush;

  assign o_vld   = (r_cnt != '0);
  assign o_full  = (r_cnt == CNT_W'(DEPTH));
  assign o_dout  = r_dout;
  // An unread cycle is one with data waiting and no read request.
  assign w_idle  = o_vld && !i_rd;
  assign w_flush = w_idle && (r_tmr == TMR_W'(TIMEOUT - 1));
  assign w_rd    = i_rd && o_vld;
  // A write landing in the flush cycle is lost with the rest of the contents.
  assign w_wr    = i_wr && !o_full && !w_flush;

  // Storage array; contents need no reset because the count gates visibility.
  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wptr] <= i_wdata;
  end

  // Pointers, occupancy, read register and timeout counter.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_tmr  <= '0;
      r_dout <= '0;
    end else if (w_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_tmr  <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) begin
        r_rptr <= r_rptr + 1'b1;
        r_dout <= r_mem[r_rptr];
      end
      r_cnt <= r_cnt + CNT_W'(w_wr) - CNT_W'(w_rd);
      r_tmr <= w_idle ? r_tmr + 1'b1 : '0;
    end
  end
endmodule

module router_1xn #(
  parameter int DATA_W     = 8,
  parameter int NUM_PORTS  = 3,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 30
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          pkt_valid,
  input  logic [DATA_W-1:0]             data_in,
  output logic                          busy,
  output logic                          error,
  output logic                          drop,
  input  logic [NUM_PORTS-1:0]          read_enb,
  output logic [NUM_PORTS-1:0]          vld_out,
  output logic [NUM_PORTS*DATA_W-1:0]   data_out
);
  localparam int ADDR_W = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_DROP} state_t;

  state_t                             r_state, w_state_nxt;
  logic [ADDR_W-1:0]                  r_dest, w_hdr_dest;
  logic [DATA_W-1:0]                  r_par, r_rx_par;
  logic                               r_err, r_drop;
  logic                               w_busy, w_wr, w_hdr_acc, w_drop_acc, w_hdr_ok;
  logic                               w_hdr_port_vld, w_dst_full;
  logic [NUM_PORTS-1:0]               w_hdr_sel, w_dst_sel, w_wr_vec, w_full;
  logic [NUM_PORTS-1:0][DATA_W-1:0]   w_dout;

  assign w_hdr_dest     = data_in[ADDR_W-1:0];
  assign w_hdr_ok       = int'(w_hdr_dest) < NUM_PORTS;
  // One-hot selects avoid indexing past the last port with a bad destination.
  assign w_hdr_port_vld = |(vld_out & w_hdr_sel);
  assign w_dst_full     = |(w_full & w_dst_sel);
  assign w_wr_vec       = w_wr ? ((r_state == S_IDLE) ? w_hdr_sel : w_dst_sel) : '0;

  assign busy     = w_busy;
  assign error    = r_err;
  assign drop     = r_drop;
  assign data_out = w_dout;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign w_hdr_sel[p] = (w_hdr_dest == ADDR_W'(p));
    assign w_dst_sel[p] = (r_dest == ADDR_W'(p));
    router_port_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) u_fifo (
      .clock   (clock),
      .resetn  (resetn),
      .i_wr    (w_wr_vec[p]),
      .i_wdata (data_in),
      .i_rd    (read_enb[p]),
      .o_vld   (vld_out[p]),
      .o_full  (w_full[p]),
      .o_dout  (w_dout[p])
    );
  end

  // Next state, busy and byte-acceptance decode.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_wr        = 1'b0;
    w_hdr_acc   = 1'b0;
    w_drop_acc  = 1'b0;
    case (r_state)
      S_IDLE: if (pkt_valid) begin
        if (!w_hdr_ok) begin
          w_drop_acc  = 1'b1;
          w_state_nxt = S_DROP;
        end else if (w_hdr_port_vld) begin
          // Destination still draining: source holds the header.
          w_busy = 1'b1;
        end else begin
          w_hdr_acc   = 1'b1;
          w_wr        = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_busy = w_dst_full;
        if (!w_dst_full) begin
          w_wr = 1'b1;
          if (!pkt_valid) w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        w_busy      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_DROP: if (!pkt_valid) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, destination latch, running parity and status flags.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_dest   <= '0;
      r_par    <= '0;
      r_rx_par <= '0;
      r_err    <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_drop  <= w_drop_acc;
      if (w_hdr_acc) begin
        r_dest <= w_hdr_dest;
        r_par  <= data_in;
        r_err  <= 1'b0;
      end
      if (r_state == S_LOAD && !w_busy) begin
        if (pkt_valid) r_par    <= r_par ^ data_in;
        else           r_rx_par <= data_in;
      end
      if (r_state == S_CHECK) r_err <= (r_par != r_rx_par);
    end
  end
endmodule

// File: tb/tb_router_1xn.sv
// Bench for router_1xn: a hand-derived vector table for the basic packet
// cases, directed sequences for back-pressure, header hold, timeout and reset,
// then random traffic checked against a queue-based packet model.
module tb_router_1xn;
  localparam int NP = 3;
  localparam int DEPTH = 16;
  localparam int TO = 30;

  logic clock, resetn, pkt_valid, busy, error, drop;
  logic [7:0] data_in;
  logic [NP-1:0] read_enb, vld_out;
  logic [NP*8-1:0] data_out;

  router_1xn #(.DATA_W(8), .NUM_PORTS(NP), .FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .busy(busy), .error(error), .drop(drop), .read_enb(read_enb),
    .vld_out(vld_out), .data_out(data_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass = 0, n_tot = 0;
  logic last_busy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: per-port byte queues plus the packet phase of the input.
  // Phase: 0 between packets, 1 inside a packet, 2 parity check, 3 discarding.
  logic [7:0] mq [NP][$];
  logic [7:0] mdo [NP];
  int mtmr [NP];
  int mph, mdest;
  logic [7:0] mpar, mrx;
  logic merr, mdrop;

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin mq[p].delete(); mdo[p] = 8'h00; mtmr[p] = 0; end
    mph = 0; mdest = 0; mpar = 8'h00; mrx = 8'h00; merr = 1'b0; mdrop = 1'b0;
  endtask

  function automatic logic m_busy(input logic pv, input logic [7:0] din);
    int d;
    d = int'(din[1:0]);
    if (mph == 2) return 1'b1;
    if (mph == 1) return mq[mdest].size() == DEPTH;
    if (mph == 0 && pv) begin
      if (d >= NP) return 1'b0;
      return mq[d].size() != 0;
    end
    return 1'b0;
  endfunction

  task automatic model_edge(input logic pv, input logic [7:0] din, input logic [NP-1:0] re);
    logic b, nd;
    int wp, d, sz;
    b = m_busy(pv, din);
    wp = -1; nd = 1'b0; d = int'(din[1:0]);
    case (mph)
      0: if (pv) begin
        if (d >= NP) begin nd = 1'b1; mph = 3; end
        else if (!b) begin wp = d; mdest = d; merr = 1'b0; mpar = din; mph = 1; end
      end
      1: if (!b) begin
        wp = mdest;
        if (pv) mpar = mpar ^ din;
        else begin mrx = din; mph = 2; end
      end
      2: begin merr = (mpar != mrx); mph = 0; end
      default: if (!pv) mph = 0;
    endcase
    mdrop = nd;
    for (int p = 0; p < NP; p++) begin
      sz = mq[p].size();
      if (sz > 0 && !re[p] && mtmr[p] == TO - 1) begin
        mq[p].delete(); mtmr[p] = 0;
      end else begin
        if (re[p] && sz > 0) mdo[p] = mq[p].pop_front();
        if (wp == p) mq[p].push_back(din);
        mtmr[p] = (sz > 0 && !re[p]) ? mtmr[p] + 1 : 0;
      end
    end
  endtask

  task automatic check_outputs(input logic pv, input logic [7:0] din);
    logic [NP-1:0] ev;
    logic [NP*8-1:0] ed;
    for (int p = 0; p < NP; p++) begin ev[p] = mq[p].size() != 0; ed[p*8 +: 8] = mdo[p]; end
    last_busy = busy;
    chk("busy", busy, m_busy(pv, din));
    chk("vld_out", vld_out, ev);
    chk("data_out", data_out, ed);
    chk("error", error, merr);
    chk("drop", drop, mdrop);
  endtask

  // Entered and left at posedge+1: drive, check at negedge, advance model at the edge.
  task automatic step(input logic pv, input logic [7:0] din, input logic [NP-1:0] re);
    pkt_valid = pv; data_in = din; read_enb = re;
    @(negedge clock);
    check_outputs(pv, din);
    @(posedge clock);
    model_edge(pv, din, re);
    #1;
  endtask

  typedef struct {
    logic pv; logic [7:0] din; logic [NP-1:0] re;
    logic busy; logic [NP-1:0] vld; logic err; logic drp; logic [NP*8-1:0] dout;
  } vec_t;
  vec_t tbl [30];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] pkt [$];
    logic [7:0] got [$];
    logic [7:0] rp [$];
    logic [7:0] par, b8;
    logic pv, acc, rd;
    logic [7:0] din;
    logic [NP-1:0] re;
    int idx, cyc, ri, hi_cnt, n;

    //       pv  din    re      busy vld     err  drp  dout {p2,p1,p0}
    tbl[0]  = '{1'b1, 8'h05, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 24'h000000};
    tbl[1]  = '{1'b1, 8'h11, 3'b000, 1'b0, 3'b010, 1'b0, 1'b0, 24'h000000};
    tbl[2]  = '{1'b1, 8'h22, 3'b000, 1'b0, 3'b010, 1'b0, 1'b0, 24'h000000};
    tbl[3]  = '{1'b0, 8'h36, 3'b000, 1'b0, 3'b010, 1'b0, 1'b0, 24'h000000};
    tbl[4]  = '{1'b0, 8'h00, 3'b010, 1'b1, 3'b010, 1'b0, 1'b0, 24'h000000};
    tbl[5]  = '{1'b0, 8'h00, 3'b010, 1'b0, 3'b010, 1'b0, 1'b0, 24'h000500};
    tbl[6]  = '{1'b0, 8'h00, 3'b010, 1'b0, 3'b010, 1'b0, 1'b0, 24'h001100};
    tbl[7]  = '{1'b0, 8'h00, 3'b010, 1'b0, 3'b010, 1'b0, 1'b0, 24'h002200};
    tbl[8]  = '{1'b0, 8'h00, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 24'h003600};
    tbl[9]  = '{1'b1, 8'h05, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 24'h003600};
    tbl[10] = '{1'b1, 8'h11, 3'b000, 1'b0, 3'b010, 1'b0, 1'b0, 24'h003600};
    tbl[11] = '{1'b1, 8'h22, 3'b000, 1'b0, 3'b010, 1'b0, 1'b0, 24'h003600};
    tbl[12] = '{1'b0, 8'h00, 3'b000, 1'b0, 3'b010, 1'b0, 1'b0, 24'h003600};
    tbl[13] = '{1'b0, 8'h00, 3'b000, 1'b1, 3'b010, 1'b0, 1'b0, 24'h003600};
    tbl[14] = '{1'b0, 8'h00, 3'b010, 1'b0, 3'b010, 1'b1, 1'b0, 24'h003600};
    tbl[15] = '{1'b0, 8'h00, 3'b010, 1'b0, 3'b010, 1'b1, 1'b0, 24'h000500};
    tbl[16] = '{1'b0, 8'h00, 3'b010, 1'b0, 3'b010, 1'b1, 1'b0, 24'h001100};
    tbl[17] = '{1'b0, 8'h00, 3'b010, 1'b0, 3'b010, 1'b1, 1'b0, 24'h002200};
    tbl[18] = '{1'b0, 8'h00, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 24'h000000};
    tbl[19] = '{1'b1, 8'h03, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 24'h000000};
    tbl[20] = '{1'b1, 8'hAA, 3'b000, 1'b0, 3'b000, 1'b1, 1'b1, 24'h000000};
    tbl[21] = '{1'b1, 8'hBB, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 24'h000000};
    tbl[22] = '{1'b0, 8'hCC, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 24'h000000};
    tbl[23] = '{1'b1, 8'h04, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 24'h000000};
    tbl[24] = '{1'b1, 8'h5A, 3'b000, 1'b0, 3'b001, 1'b0, 1'b0, 24'h000000};
    tbl[25] = '{1'b0, 8'h5E, 3'b000, 1'b0, 3'b001, 1'b0, 1'b0, 24'h000000};
    tbl[26] = '{1'b0, 8'h00, 3'b001, 1'b1, 3'b001, 1'b0, 1'b0, 24'h000000};
    tbl[27] = '{1'b0, 8'h00, 3'b001, 1'b0, 3'b001, 1'b0, 1'b0, 24'h000004};
    tbl[28] = '{1'b0, 8'h00, 3'b001, 1'b0, 3'b001, 1'b0, 1'b0, 24'h00005A};
    tbl[29] = '{1'b0, 8'h00, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 24'h00005E};

    // Reset state
    resetn = 1'b0; pkt_valid = 1'b0; data_in = 8'h00; read_enb = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_vld", vld_out, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_error", error, 0);
    chk("rst_drop", drop, 0);
    @(negedge clock); resetn = 1'b1;
    @(posedge clock); #1;

    // Normal packet, bad parity, invalid destination, recovery to port 0
    for (int i = 0; i < 30; i++) begin
      pkt_valid = tbl[i].pv; data_in = tbl[i].din; read_enb = tbl[i].re;
      @(negedge clock);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("tbl%0d_vld", i), vld_out, tbl[i].vld);
      chk($sformatf("tbl%0d_err", i), error, tbl[i].err);
      chk($sformatf("tbl%0d_drop", i), drop, tbl[i].drp);
      chk($sformatf("tbl%0d_dout", i), data_out, tbl[i].dout);
      @(posedge clock);
      model_edge(tbl[i].pv, tbl[i].din, tbl[i].re);
      #1;
    end

    // Full back-pressure: 22-byte packet to port 2, reads start late
    pkt.delete(); got.delete();
    pkt.push_back(8'h02); par = 8'h02;
    for (int i = 1; i <= 20; i++) begin b8 = 8'(8'h80 + i); pkt.push_back(b8); par = par ^ b8; end
    pkt.push_back(par);
    idx = 0; cyc = 0;
    while (got.size() < 22 && cyc < 200) begin
      pv = (idx < 21); din = (idx < 22) ? pkt[idx] : 8'h00;
      re = (cyc >= 20) ? 3'b100 : 3'b000;
      acc = !m_busy(pv, din);
      rd = re[2] && (mq[2].size() > 0);
      step(pv, din, re);
      if (cyc == 16) chk("full_busy", last_busy, 1);
      if (idx < 22 && acc) idx++;
      if (rd) got.push_back(data_out[23:16]);
      cyc++;
    end
    chk("full_count", got.size(), 22);
    for (int i = 0; i < 22 && i < got.size(); i++) chk($sformatf("full_byte%0d", i), got[i], pkt[i]);
    step(0, 8'h00, 3'b000);

    // Header to a non-empty port is held until that port drains
    step(1, 8'h01, 3'b000); step(1, 8'h77, 3'b000); step(0, 8'h76, 3'b000);
    cyc = 0; acc = 1'b0;
    while (!acc && cyc < 50) begin
      re = (cyc >= 6) ? 3'b010 : 3'b000;
      acc = !m_busy(1'b1, 8'h01);
      step(1, 8'h01, re);
      if (cyc == 3) chk("hold_busy", last_busy, 1);
      cyc++;
    end
    chk("hold_accepted", acc, 1);
    step(1, 8'h99, 3'b000); step(0, 8'h98, 3'b000);
    repeat (5) step(0, 8'h00, 3'b010);
    chk("hold_error", error, 0);

    // Timeout: port 0 unread is flushed after 30 cycles with data
    hi_cnt = 0;
    step(1, 8'h00, 3'b000); if (vld_out[0]) hi_cnt++;
    step(0, 8'h00, 3'b000); if (vld_out[0]) hi_cnt++;
    repeat (40) begin step(0, 8'h00, 3'b000); if (vld_out[0]) hi_cnt++; end
    chk("timeout_cycles", hi_cnt, TO);

    // Asynchronous reset mid-payload
    step(1, 8'h00, 3'b000); step(0, 8'h55, 3'b000); step(0, 8'h00, 3'b000);
    chk("pre_rst_error", error, 1);
    step(1, 8'h02, 3'b000); step(1, 8'h10, 3'b000); step(1, 8'h20, 3'b000);
    chk("pre_rst_vld", vld_out, 3'b101);
    pkt_valid = 1'b1; data_in = 8'h30; read_enb = '0;
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_vld", vld_out, 0);
    chk("mid_rst_dout", data_out, 0);
    chk("mid_rst_error", error, 0);
    chk("mid_rst_drop", drop, 0);
    model_reset();
    @(negedge clock); resetn = 1'b1;
    check_outputs(1'b1, 8'h30);
    @(posedge clock);
    model_edge(1'b1, 8'h30, 3'b000);
    #1;
    step(1, 8'h40, 3'b000); step(0, 8'h70, 3'b000);
    repeat (5) step(0, 8'h00, 3'b001);

    // Random traffic against the model
    rp.delete(); ri = 0;
    for (int c = 0; c < 3000; c++) begin
      if (rp.size() == 0 && $urandom_range(0, 3) == 0) begin
        b8 = 8'($urandom); rp.push_back(b8); par = b8;
        n = $urandom_range(0, 20);
        for (int k = 0; k < n; k++) begin b8 = 8'($urandom); rp.push_back(b8); par = par ^ b8; end
        if ($urandom_range(0, 3) == 0) par = par ^ 8'h01;
        rp.push_back(par); ri = 0;
      end
      if (rp.size() != 0) begin pv = (ri < rp.size() - 1); din = rp[ri]; end
      else begin pv = 1'b0; din = 8'($urandom); end
      if ((c / 250) % 2 == 0) re = 3'($urandom_range(0, 7));
      else re = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      acc = !m_busy(pv, din);
      step(pv, din, re);
      if (rp.size() != 0 && acc) begin
        ri++;
        if (ri == rp.size()) begin rp.delete(); ri = 0; end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
